// File: rtl/mux2_chk_pkg.sv
// mux2_chk_pkg: shared types and helpers for the Logic_mux2 response checker.
//   state_t     - checker FSM states (IDLE, RUN, DONE)
//   stage_t     - one delay-pipeline entry {valid, a, b, c, idx}
//   mux2_golden - reference 2:1 mux, y = c ? b : a
//   MAX_LATENCY - largest supported alignment latency
//   IDX_W       - width of the idx field carried through the pipeline (ITER_W must not exceed it)
package mux2_chk_pkg;

    localparam int unsigned MAX_LATENCY = 7;
    localparam int unsigned IDX_W       = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             a;
        logic             b;
        logic             c;
        logic [IDX_W-1:0] idx;
    } stage_t;

    function automatic logic mux2_golden(input logic a, input logic b, input logic c);
        return c ? b : a;
    endfunction

endpackage

// File: rtl/mux2_chk_delay.sv
// mux2_chk_delay: LATENCY-deep shift register of stage_t that aligns an accepted
// stimulus vector with the DUT output it produced. LATENCY=0 is a pure wire.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears every stage
//   clr_i   - synchronous flush of every stage (discards in-flight entries)
//   stage_i - entry written this cycle
//   stage_o - entry leaving the pipeline (stage_i itself when LATENCY=0)
module mux2_chk_delay
    import mux2_chk_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clr_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    if (LATENCY == 0) begin : g_bypass
        assign stage_o = stage_i;

        logic unused_ctrl;
        assign unused_ctrl = clk_i ^ rst_ni ^ clr_i;
    end else begin : g_pipe
        stage_t pipe_q [LATENCY];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (clr_i) begin
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= stage_i;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign stage_o = pipe_q[LATENCY-1];
    end

endmodule

// File: rtl/mux2_resp_checker.sv
// mux2_resp_checker: checks a 2:1 mux DUT output y against y = c ? b : a,
// aligned to the stimulus by LATENCY cycles (0..7).
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   start, num_iter      - start pulse and number of vectors to check (sampled on start)
//   stim_valid, a, b, c  - stimulus vector as driven to the DUT
//   y                    - DUT output
//   busy, done, pass     - RUN state, DONE state, DONE with no mismatches
//   chk_cnt, err_cnt     - comparisons performed, mismatches (saturating)
//   fail_idx, fail_vec   - index and {a,b,c,y} of the first mismatch
// Optional build macro MUX2_CHK_HALT_ON_FAIL_EN: stop the run at the first mismatch.
module mux2_resp_checker
    import mux2_chk_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ITER_W  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              stim_valid,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ITER_W-1:0] chk_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ITER_W-1:0] fail_idx,
    output logic [3:0]        fail_vec
);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] num_q, num_d;
    logic [ITER_W-1:0] acc_q, acc_d;
    logic [ITER_W-1:0] chk_q, chk_d;
    logic [ITER_W-1:0] fidx_q, fidx_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [3:0]        fvec_q, fvec_d;

    stage_t in_st;
    stage_t cmp_st;
    logic   accept;
    logic   cmp_en;
    logic   exp_y;
    logic   mism;

    assign accept = (state_q == RUN) && stim_valid && (acc_q < num_q);

    always_comb begin
        in_st       = '0;
        in_st.valid = accept;
        in_st.a     = a;
        in_st.b     = b;
        in_st.c     = c;
        in_st.idx   = IDX_W'(acc_q);
    end

    // Anything left in the pipeline outside RUN belongs to a finished or
    // aborted run, so the pipeline is held empty there.
    mux2_chk_delay #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (state_q != RUN),
        .stage_i (in_st),
        .stage_o (cmp_st)
    );

    if (ITER_W < IDX_W) begin : g_idx_hi
        logic unused_idx_hi;
        assign unused_idx_hi = ^cmp_st.idx[IDX_W-1:ITER_W];
    end

    assign cmp_en = (state_q == RUN) && cmp_st.valid;
    assign exp_y  = mux2_golden(cmp_st.a, cmp_st.b, cmp_st.c);
    // Case inequality so an X/Z on y registers as a mismatch in simulation.
    assign mism   = (y !== exp_y);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        chk_d   = chk_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fvec_d  = fvec_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d   = num_iter;
                    acc_d   = '0;
                    chk_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fvec_d  = '0;
                    state_d = (num_iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + ITER_W'(1);
                end
                if (cmp_en) begin
                    chk_d = chk_q + ITER_W'(1);
                    if (mism) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (err_q == '0) begin
                            fidx_d = cmp_st.idx[ITER_W-1:0];
                            fvec_d = {cmp_st.a, cmp_st.b, cmp_st.c, y};
                        end
`ifdef MUX2_CHK_HALT_ON_FAIL_EN
                        state_d = DONE;
`endif
                    end
                end
                if (chk_q == num_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            acc_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fvec_q  <= fvec_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = (state_q == DONE) && (err_q == '0);
    assign chk_cnt  = chk_q;
    assign err_cnt  = err_q;
    assign fail_idx = fidx_q;
    assign fail_vec = fvec_q;

endmodule

// File: tb/tb_mux2_resp_checker.sv
// Bench for mux2_resp_checker. Four checkers share one stimulus stream:
//   k=0: LATENCY=1 vs DUT delay 1   k=1: LATENCY=0 vs DUT delay 0
//   k=2: LATENCY=3 vs DUT delay 3   k=3: LATENCY=2 vs DUT delay 1 (misaligned)
// A timeline model (accept cycle + latency -> compare cycle) predicts every
// output each cycle; literal checks pin the model on the planned scenarios.
module tb_mux2_resp_checker;

`ifdef MUX2_CHK_HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif
    localparam logic [15:0] LATS = {4'd2, 4'd3, 4'd0, 4'd1};
    localparam logic [15:0] DLYS = {4'd1, 4'd3, 4'd0, 4'd1};
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_iter = '0;
    logic        stim_valid = 1'b0;
    logic        a = 1'b0, b = 1'b0, c = 1'b0;
    logic        force0 = 1'b0, stuck = 1'b0;
    logic        ycur;
    logic [7:0]  ydel = '0;
    logic [3:0]  y_w, busy_w, done_w, pass_w;
    logic [15:0] chk_w [4];
    logic [15:0] err_w [4];
    logic [15:0] fidx_w [4];
    logic [3:0]  fvec_w [4];

    int n_pass = 0, n_total = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        mux2_resp_checker #(
            .LATENCY (int'(LATS[4*k +: 4])),
            .ITER_W  (16),
            .CNT_W   (16)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .num_iter   (num_iter),
            .stim_valid (stim_valid),
            .a          (a),
            .b          (b),
            .c          (c),
            .y          (y_w[k]),
            .busy       (busy_w[k]),
            .done       (done_w[k]),
            .pass       (pass_w[k]),
            .chk_cnt    (chk_w[k]),
            .err_cnt    (err_w[k]),
            .fail_idx   (fidx_w[k]),
            .fail_vec   (fvec_w[k])
        );
    end

    // Emulated mux DUTs: ideal output, optionally corrupted, delayed by DLYS[k].
    assign ycur = (stuck || force0) ? 1'b0 : (c ? b : a);
    always @(posedge clk) ydel <= {ydel[6:0], ycur};
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (DLYS[4*k +: 4] == 4'd0) y_w[k] = ycur;
            else                        y_w[k] = ydel[DLYS[4*k +: 4] - 4'd1];
        end
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gold(input logic [2:0] v);
        return v[0] ? v[1] : v[2];
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
        else n_pass++;
    endtask

    // ---------------- timeline model ----------------
    bit         m_started [4];
    int         m_num [4], m_acc [4], m_cmp [4], m_err [4], m_fidx [4], m_done_at [4];
    logic [3:0] m_fvec [4];
    logic [2:0] m_vec [4][64];
    int         m_ta [4][64];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                m_started[k] = 1'b0; m_num[k] = 0; m_acc[k] = 0; m_cmp[k] = 0;
                m_err[k] = 0; m_fidx[k] = 0; m_fvec[k] = '0; m_done_at[k] = 0;
            end else if (start && !(m_started[k] && cyc < m_done_at[k])) begin
                m_started[k] = 1'b1; m_num[k] = int'(num_iter); m_acc[k] = 0; m_cmp[k] = 0;
                m_err[k] = 0; m_fidx[k] = 0; m_fvec[k] = '0;
                m_done_at[k] = (num_iter == 16'd0) ? cyc + 1 : BIG;
            end else if (m_started[k] && cyc < m_done_at[k]) begin
                if (stim_valid && m_acc[k] < m_num[k] && m_acc[k] < 64) begin
                    m_ta[k][m_acc[k]]  = cyc;
                    m_vec[k][m_acc[k]] = {a, b, c};
                    m_acc[k]++;
                end
                if (m_cmp[k] < m_acc[k] && m_ta[k][m_cmp[k]] + int'(LATS[4*k +: 4]) == cyc) begin
                    logic bad;
                    bad = (y_w[k] !== gold(m_vec[k][m_cmp[k]]));
                    if (bad) begin
                        if (m_err[k] == 0) begin
                            m_fidx[k] = m_cmp[k];
                            m_fvec[k] = {m_vec[k][m_cmp[k]], y_w[k]};
                        end
                        m_err[k]++;
                    end
                    m_cmp[k]++;
                    if (m_cmp[k] == m_num[k]) m_done_at[k] = cyc + 2;
                    if (HALT && bad) m_done_at[k] = cyc + 1;
                end
            end
        end
    end

    // One compare process: every cycle, every checker, every output.
    always @(negedge clk) begin
        if ($time > 2) begin
            for (int k = 0; k < 4; k++) begin
                logic ed;
                ed = m_started[k] && cyc >= m_done_at[k];
                check("busy",     k, 32'(busy_w[k]), 32'(m_started[k] && cyc < m_done_at[k]));
                check("done",     k, 32'(done_w[k]), 32'(ed));
                check("pass",     k, 32'(pass_w[k]), 32'(ed && m_err[k] == 0));
                check("chk_cnt",  k, 32'(chk_w[k]),  32'(m_cmp[k]));
                check("err_cnt",  k, 32'(err_w[k]),  32'(m_err[k]));
                check("fail_idx", k, 32'(fidx_w[k]), 32'(m_fidx[k]));
                check("fail_vec", k, 32'(fvec_w[k]), 32'(m_fvec[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        num_iter = 16'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] v, input logic f0);
        {a, b, c} = v;
        force0 = f0;
        stim_valid = 1'b1;
        tick;
        stim_valid = 1'b0;
        force0 = 1'b0;
    endtask

    task automatic wait_all_done;
        int n;
        n = 0;
        while (done_w != 4'hF && n < 80) begin
            tick;
            n++;
        end
        check("done_timeout", 0, 32'(done_w), 32'hF);
    endtask

    task automatic run_alt10(input int bad_idx);
        do_start(10);
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 3'b110 : 3'b001, i == bad_idx);
        wait_all_done;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick;
        check("rst_busy", 0, 32'(busy_w[0]), 0);
        check("rst_chk",  0, 32'(chk_w[0]),  0);
        rst_n = 1'b1;
        tick;

        // Clean 10-vector run.
        run_alt10(-1);
        check("t1_pass", 0, 32'(pass_w[0]), 1);
        check("t1_chk",  0, 32'(chk_w[0]),  10);
        check("t1_err",  0, 32'(err_w[0]),  0);

        // y forced low on the third vector (1,1,0).
        run_alt10(2);
        check("t2_err",   0, 32'(err_w[0]),  1);
        check("t2_fidx",  0, 32'(fidx_w[0]), 2);
        check("t2_fvec",  0, 32'(fvec_w[0]), 32'b1100);
        check("t2_pass",  0, 32'(pass_w[0]), 0);
        check("t2_chk",   0, 32'(chk_w[0]),  HALT ? 3 : 10);

        // Extra vectors beyond num_iter are ignored.
        do_start(4);
        for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 3'b110 : 3'b001, 1'b0);
        wait_all_done;
        check("t3_chk",  0, 32'(chk_w[0]), 4);
        check("t3_pass", 0, 32'(pass_w[0]), 1);

        // num_iter == 0 completes immediately.
        do_start(0);
        check("t3_zero_done", 0, 32'(done_w[0]), 1);
        check("t3_zero_pass", 0, 32'(pass_w[0]), 1);

        // Eight back-to-back vectors, all input combinations.
        do_start(8);
        for (int v = 0; v < 8; v++) send(3'(v), 1'b0);
        wait_all_done;
        check("t4_lat0_err", 1, 32'(err_w[1]), 0);
        check("t4_lat3_err", 2, 32'(err_w[2]), 0);
        check("t4_lat3_chk", 2, 32'(chk_w[2]), 8);
        check("t4_misalign_err_nz", 3, 32'(err_w[3] != 16'd0), 1);

        // Reset in the middle of a run.
        do_start(10);
        for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 3'b110 : 3'b001, 1'b0);
        check("t5_chk_mid", 0, 32'(chk_w[0]), 5);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 0, 32'(busy_w[0]), 0);
        check("t5_rst_done", 0, 32'(done_w[0]), 0);
        check("t5_rst_chk",  0, 32'(chk_w[0]),  0);
        check("t5_rst_err",  0, 32'(err_w[0]),  0);
        tick;
        rst_n = 1'b1;
        tick;
        run_alt10(-1);
        check("t5_after_pass", 0, 32'(pass_w[0]), 1);
        check("t5_after_chk",  0, 32'(chk_w[0]),  10);

        // y stuck at 0.
        stuck = 1'b1;
        do_start(10);
        send(3'b110, 1'b0);
        send(3'b001, 1'b0);
        check("t6_done_early", 0, 32'(done_w[0]), 32'(HALT));
        for (int i = 2; i < 10; i++) send((i % 2 == 0) ? 3'b110 : 3'b001, 1'b0);
        wait_all_done;
        stuck = 1'b0;
        check("t6_err",  0, 32'(err_w[0]),  HALT ? 1 : 5);
        check("t6_fidx", 0, 32'(fidx_w[0]), 0);
        check("t6_chk",  0, 32'(chk_w[0]),  HALT ? 32'(fidx_w[0]) + 1 : 10);
        check("t6_fvec", 0, 32'(fvec_w[0]), 32'b1100);

        repeat (2) tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux2_resp_checker.md
Name: mux2_resp_checker

Overview:
- Synthesizable response checker for the Logic_mux2 stimulus flow.
- The stimulus side writes {a,b,c} vectors; this block reads the DUT output y and compares it against the golden 2:1 mux function y = c ? b : a, using a programmable alignment latency.
- It counts checks and mismatches, captures the first failing vector, and reports pass/done.
- It sits beside the DUT in self-checking benches and in FPGA bring-up wrappers.

Parameters:
- LATENCY, 1, cycles from stimulus-valid to the y sample; legal 0..7.
- ITER_W, 16, width of iteration count and indices.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a run.
- num_iter  in  ITER_W  number of vectors to check; sampled on start.
- stim_valid  in  1  a/b/c carry a new vector this cycle.
- a  in  1  mux data input 0, as driven to the DUT.
- b  in  1  mux data input 1, as driven to the DUT.
- c  in  1  mux select, as driven to the DUT.
- y  in  1  DUT output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_cnt==0.
- chk_cnt  out  ITER_W  number of comparisons performed.
- err_cnt  out  CNT_W  number of mismatches; saturates at all-ones.
- fail_idx  out  ITER_W  index (0-based) of the first mismatch.
- fail_vec  out  4  {a,b,c,y} of the first mismatch.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - FSM goes to IDLE.
  - busy, done and pass are 0.
  - chk_cnt, err_cnt, fail_idx and fail_vec are 0.
  - The delay pipeline is cleared, with all valid bits at 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE on start: latch num_iter, clear all counters and capture registers, go to RUN. If num_iter==0, go straight to DONE with pass=1.
  - RUN: start is ignored. Go to DONE the cycle after chk_cnt reaches num_iter.
  - DONE on start: behaves exactly as start in IDLE (restart). Outputs hold until then.
- Accept counter:
  - In RUN, stim_valid accepts a vector while acc_cnt < num_iter.
  - Vectors beyond num_iter, and stim_valid outside RUN, are dropped.
- Delay pipeline:
  - LATENCY stages of {valid,a,b,c,idx}.
  - With LATENCY=0 the comparison uses the same-cycle stimulus and y, as a combinational path to the compare register.
- Compare:
  - When the pipeline output is valid, exp = c ? b : a, and y is sampled that cycle.
  - chk_cnt increments by 1.
  - On y != exp: err_cnt increments (saturating). On the first mismatch only, fail_idx and fail_vec are captured.
  - In simulation, an X/Z on y counts as a mismatch.
- Latency: err_cnt and chk_cnt update 1 cycle after the compare sample; done asserts 1 cycle after the final chk_cnt update.
- Simultaneous events: accept and compare in the same cycle are both honoured. Back-to-back stim_valid every cycle is supported at full rate.
- Reset mid-run: everything returns to reset values immediately and in-flight pipeline entries are discarded.

Optional Feature:
- Macro: MUX2_CHK_HALT_ON_FAIL_EN.
- Defined: the first mismatch moves the FSM to DONE on the next cycle with pass=0. Pending pipeline entries are discarded, and chk_cnt and err_cnt freeze (err_cnt==1).
- Undefined: the run always completes all num_iter checks.

Decomposition:
- Package mux2_chk_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - stage_t packed struct {valid,a,b,c,idx}.
  - function mux2_golden(a,b,c).
  - MAX_LATENCY=7.
- Sub-module mux2_chk_delay: parameterized LATENCY-deep shift register of stage_t, with a LATENCY=0 bypass.

Test Plan:
- Correct DUT, LATENCY=1, num_iter=10, vectors alternating (a,b,c)=(1,1,0),(0,0,1), y driven correctly (1,0,...) -> done=1, pass=1, chk_cnt=10, err_cnt=0.
- Same stimulus, y forced 0 on the iteration-3 vector (1,1,0) -> err_cnt=1, fail_idx=2, fail_vec=4'b1100, pass=0.
- num_iter=4 with 6 stim_valid pulses -> chk_cnt=4, extra vectors ignored; start with num_iter=0 -> DONE in 1 cycle, pass=1.
- LATENCY=0 and LATENCY=3 runs with y delayed to match, 8 back-to-back vectors -> err_cnt=0. Misaligned LATENCY=2 against a DUT delay of 1 -> err_cnt>0.
- rst_n asserted after 5 of 10 checks -> all outputs 0 asynchronously. A new start then gives a clean 10-vector pass.
- With MUX2_CHK_HALT_ON_FAIL_EN and y stuck at 0 -> done 1 cycle after the first mismatch, err_cnt=1, chk_cnt=fail_idx+1.
